// File: rtl/gdu_pkg.sv
// gdu_pkg: types and constants shared between the master arbiter and
// graphics_drawing_unit.
package gdu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE_BURST,
      ST_READ_CMD,
      ST_READ_DRAIN
   } arb_state_t;

   localparam logic REQ_BLIT = 1'b0;
   localparam logic REQ_AUX  = 1'b1;

   // One-hot grant vector for a requester index.
   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/gdu_master_arbiter_if.sv
// gdu_master_arbiter_if: one Avalon-MM master/slave link. The master modport
// issues commands; the slave modport answers with stall and read data.
interface gdu_master_arbiter_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 5
);

   logic [ADDR_W-1:0]   address;
   logic [BURST_W-1:0]  burstcount;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, burstcount, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/gdu_master_arbiter.sv
// gdu_master_arbiter: shares the single SDRAM Avalon-MM master port between
// the blitter (r0) and a second client (r1) with round-robin fairness. A grant
// is held until the whole transaction, including every read beat, completes.
module gdu_master_arbiter
   import gdu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   gdu_master_arbiter_if.slave  r0,
   gdu_master_arbiter_if.slave  r1,
   gdu_master_arbiter_if.master avalon_master,
   output logic [1:0]           grant_export
);

   arb_state_t          state;
   logic                gnt_idx;    // requester owning the downstream port
   logic                last;       // requester that completed the previous transaction
   logic [BURST_W:0]    burst_len;  // one bit wider so a full burst never wraps
   logic [BURST_W:0]    beat_cnt;
   logic [BURST_W:0]    beat_next;

   logic                req0, req1, pick, pick_write;
   logic [BURST_W-1:0]  pick_burstcount;
   logic                in_cmd, in_read;
   logic                wr_beat, rd_accept, rd_beat;

   logic [ADDR_W-1:0]   sel_address;
   logic [BURST_W-1:0]  sel_burstcount;
   logic [DATA_W/8-1:0] sel_byteenable;
   logic [DATA_W-1:0]   sel_writedata;
   logic                sel_read, sel_write;

   assign req0 = r0.read | r0.write;
   assign req1 = r1.read | r1.write;

   // Round-robin pick; on a tie the requester not served last wins.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pick = REQ_BLIT;
      if (req0 && req1) pick = ~last;
      else if (req1)    pick = REQ_AUX;
      pick_burstcount = pick ? r1.burstcount : r0.burstcount;
      pick_write      = pick ? r1.write      : r0.write;
   end

   // Command mux: the latched grant index selects whose command goes downstream.
   always_comb begin
      if (gnt_idx == REQ_AUX) begin
         sel_address    = r1.address;
         sel_burstcount = r1.burstcount;
         sel_byteenable = r1.byteenable;
         sel_writedata  = r1.writedata;
         sel_read       = r1.read;
         sel_write      = r1.write;
      end else begin
         sel_address    = r0.address;
         sel_burstcount = r0.burstcount;
         sel_byteenable = r0.byteenable;
         sel_writedata  = r0.writedata;
         sel_read       = r0.read;
         sel_write      = r0.write;
      end
   end

   assign in_cmd  = (state == ST_WRITE_BURST) || (state == ST_READ_CMD);
   assign in_read = (state == ST_READ_CMD) || (state == ST_READ_DRAIN);

   assign avalon_master.address    = sel_address;
   assign avalon_master.burstcount = sel_burstcount;
   assign avalon_master.byteenable = sel_byteenable;
   assign avalon_master.writedata  = sel_writedata;
   assign avalon_master.read       = (state == ST_READ_CMD) && sel_read;
   assign avalon_master.write      = (state == ST_WRITE_BURST) && sel_write;

   // Only the granted requester sees the real stall and its read beats.
   assign r0.waitrequest   = (in_cmd && gnt_idx == REQ_BLIT) ? avalon_master.waitrequest : 1'b1;
   assign r1.waitrequest   = (in_cmd && gnt_idx == REQ_AUX)  ? avalon_master.waitrequest : 1'b1;
   assign r0.readdatavalid = in_read && (gnt_idx == REQ_BLIT) && avalon_master.readdatavalid;
   assign r1.readdatavalid = in_read && (gnt_idx == REQ_AUX)  && avalon_master.readdatavalid;
   assign r0.readdata      = avalon_master.readdata;
   assign r1.readdata      = avalon_master.readdata;

   assign wr_beat   = avalon_master.write && !avalon_master.waitrequest;
   assign rd_accept = avalon_master.read && !avalon_master.waitrequest;
   assign rd_beat   = in_read && avalon_master.readdatavalid;
   assign beat_next = beat_cnt + 1'b1;

   // Arbiter FSM: grant, count beats, release and remember who was served.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         gnt_idx      <= REQ_BLIT;
         last         <= REQ_AUX;
         burst_len    <= '0;
         beat_cnt     <= '0;
         grant_export <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req0 || req1) begin
                  gnt_idx      <= pick;
                  grant_export <= req_onehot(pick);
                  burst_len    <= (pick_burstcount == '0) ? (BURST_W+1)'(1)
                                                          : {1'b0, pick_burstcount};
                  beat_cnt     <= '0;
                  // A write wins over a simultaneous read from the same requester.
                  state        <= pick_write ? ST_WRITE_BURST : ST_READ_CMD;
               end
            end
            ST_WRITE_BURST: begin
               if (wr_beat) begin
                  if (beat_next == burst_len) begin
                     state        <= ST_IDLE;
                     last         <= gnt_idx;
                     grant_export <= 2'b00;
                     beat_cnt     <= '0;
                  end else begin
                     beat_cnt <= beat_next;
                  end
               end
            end
            ST_READ_CMD: begin
               if (rd_beat) beat_cnt <= beat_next;
               if (rd_accept) begin
                  if (rd_beat && beat_next == burst_len) begin
                     state        <= ST_IDLE;
                     last         <= gnt_idx;
                     grant_export <= 2'b00;
                     beat_cnt     <= '0;
                  end else begin
                     state <= ST_READ_DRAIN;
                  end
               end
            end
            ST_READ_DRAIN: begin
               if (rd_beat) begin
                  if (beat_next == burst_len) begin
                     state        <= ST_IDLE;
                     last         <= gnt_idx;
                     grant_export <= 2'b00;
                     beat_cnt     <= '0;
                  end else begin
                     beat_cnt <= beat_next;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gdu_master_arbiter.sv
// tb_gdu_master_arbiter: table-driven arbitration vectors plus hand-written
// multi-cycle sequences; read beats are checked through a scoreboard queue.
module tb_gdu_master_arbiter;
   import gdu_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int BURST_W = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] grant_export;

   gdu_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) r0_if ();
   gdu_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) r1_if ();
   gdu_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) am_if ();

   gdu_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .r0           (r0_if),
      .r1           (r1_if),
      .avalon_master(am_if),
      .grant_export (grant_export)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic                idx;
      logic [DATA_W-1:0]   data;
   } beat_t;
   beat_t exp_q[$];
   beat_t mon_e;

   typedef struct {
      logic       r0_rd, r0_wr, r1_rd, r1_wr;
      logic [4:0] r0_bc, r1_bc;
      logic [1:0] exp_grant;
      logic       exp_rd, exp_wr;
      int         exp_beats;
   } vec_t;
   vec_t vecs[8];

   int gaps[7] = '{0, 1, 0, 3, 0, 1, 2};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic set_req(input logic idx, input logic rd, input logic wr,
                          input logic [4:0] bc, input logic [31:0] addr);
      if (idx) begin
         r1_if.read = rd; r1_if.write = wr; r1_if.burstcount = bc;
         r1_if.address = addr; r1_if.writedata = ~addr; r1_if.byteenable = 4'hF;
      end else begin
         r0_if.read = rd; r0_if.write = wr; r0_if.burstcount = bc;
         r0_if.address = addr; r0_if.writedata = ~addr; r0_if.byteenable = 4'hF;
      end
   endtask

   // Advance to the next falling edge; read-beat strobes are one-shot.
   task automatic cyc();
      @(negedge clk);
      am_if.readdatavalid = 1'b0;
   endtask

   task automatic dn_beat(input logic fwd, input logic idx, input logic [31:0] d);
      am_if.readdatavalid = 1'b1;
      am_if.readdata      = d;
      if (fwd) exp_q.push_back('{idx: idx, data: d});
   endtask

   // Scoreboard monitor: every forwarded beat must match the queue head.
   always @(negedge clk) begin
      #2;
      if (r0_if.readdatavalid || r1_if.readdatavalid) begin
         if (exp_q.size() == 0) begin
            check("rdv_unexpected_beat", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            check("rdv_route", {r1_if.readdatavalid, r0_if.readdatavalid}, req_onehot(mon_e.idx));
            check("rdv_data", mon_e.idx ? r1_if.readdata : r0_if.readdata, mon_e.data);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      int beats, guard;
      logic win;

      // Stimulus table; the expected grant follows the round-robin history
      // left by the single r0 read before it (last = r0).
      vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd1,  5'd2,  2'b10, 1'b1, 1'b0, 2};  // r1 read only
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  5'd2,  2'b01, 1'b0, 1'b1, 3};  // tie, last=r1
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd1,  5'd1,  2'b10, 1'b1, 1'b0, 1};  // tie, last=r0
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  5'd1,  2'b01, 1'b0, 1'b1, 2};  // read+write: write wins
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  2'b01, 1'b0, 1'b1, 1};  // burstcount 0
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  5'd0,  2'b10, 1'b0, 1'b1, 1};  // tie, last=r0
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd16, 2'b10, 1'b0, 1'b1, 16}; // max burst
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  5'd2,  2'b01, 1'b0, 1'b1, 2};  // tie, last=r1

      reset = 1'b1;
      set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);
      set_req(REQ_AUX,  1'b0, 1'b0, 5'd0, 32'h0);
      am_if.waitrequest   = 1'b0;
      am_if.readdatavalid = 1'b0;
      am_if.readdata      = '0;

      // Reset state
      repeat (2) cyc();
      #1;
      check("rst_grant", grant_export, 2'b00);
      check("rst_r0_wait", r0_if.waitrequest, 1'b1);
      check("rst_r1_wait", r1_if.waitrequest, 1'b1);
      check("rst_dn_rw", {am_if.read, am_if.write}, 2'b00);
      check("rst_rdv", {r1_if.readdatavalid, r0_if.readdatavalid}, 2'b00);
      cyc();
      reset = 1'b0;

      // Single read, r0 only, burstcount 1
      cyc();
      set_req(REQ_BLIT, 1'b1, 1'b0, 5'd1, 32'h100);
      #1;
      check("rd1_idle_wait", r0_if.waitrequest, 1'b1);
      check("rd1_idle_grant", grant_export, 2'b00);
      cyc(); #1;
      check("rd1_grant", grant_export, 2'b01);
      check("rd1_dn_read", am_if.read, 1'b1);
      check("rd1_dn_addr", am_if.address, 32'h100);
      check("rd1_r0_wait", r0_if.waitrequest, 1'b0);
      cyc();
      set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);
      dn_beat(1'b1, REQ_BLIT, 32'hA5A5_0001);
      #1;
      check("rd1_hold", grant_export, 2'b01);
      cyc(); #1;
      check("rd1_release", grant_export, 2'b00);

      // Table-driven arbitration vectors
      for (int v = 0; v < 8; v++) begin
         cyc();
         set_req(REQ_BLIT, vecs[v].r0_rd, vecs[v].r0_wr, vecs[v].r0_bc, 32'h1000 + v);
         set_req(REQ_AUX,  vecs[v].r1_rd, vecs[v].r1_wr, vecs[v].r1_bc, 32'h2000 + v);
         #1;
         check("vec_idle_grant", grant_export, 2'b00);
         cyc(); #1;
         win = vecs[v].exp_grant[1];
         check("vec_grant", grant_export, vecs[v].exp_grant);
         check("vec_dn_read", am_if.read, vecs[v].exp_rd);
         check("vec_dn_write", am_if.write, vecs[v].exp_wr);
         check("vec_dn_addr", am_if.address, win ? 32'h2000 + v : 32'h1000 + v);
         check("vec_loser_wait", win ? r0_if.waitrequest : r1_if.waitrequest, 1'b1);
         if (vecs[v].exp_wr) begin
            beats = (am_if.write && !am_if.waitrequest) ? 1 : 0;
            set_req(~win, 1'b0, 1'b0, 5'd0, 32'h0);
            guard = 0;
            do begin
               cyc(); #1;
               if (grant_export != 2'b00 && am_if.write && !am_if.waitrequest) beats++;
               guard++;
            end while (grant_export != 2'b00 && guard < 40);
            set_req(win, 1'b0, 1'b0, 5'd0, 32'h0);
            check("vec_write_beats", beats, vecs[v].exp_beats);
            check("vec_release", grant_export, 2'b00);
         end else begin
            for (int i = 0; i < vecs[v].exp_beats; i++) begin
               cyc();
               if (i == 0) begin
                  set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);
                  set_req(REQ_AUX,  1'b0, 1'b0, 5'd0, 32'h0);
               end
               dn_beat(1'b1, win, 32'hC000_0000 | (v << 8) | i);
               #1;
               check("vec_read_hold", grant_export, vecs[v].exp_grant);
            end
            cyc(); #1;
            check("vec_release", grant_export, 2'b00);
         end
      end

      // Tie after reset: r0 first for 4 beats, r1 one cycle later, then r0 again
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      set_req(REQ_BLIT, 1'b0, 1'b1, 5'd4, 32'h3000);
      set_req(REQ_AUX,  1'b0, 1'b1, 5'd4, 32'h4000);
      #1;
      check("tie_idle_wait", {r1_if.waitrequest, r0_if.waitrequest}, 2'b11);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         check("tie_r0_grant", grant_export, 2'b01);
         check("tie_r0_beat", am_if.write && !am_if.waitrequest, 1'b1);
         check("tie_r1_wait", r1_if.waitrequest, 1'b1);
      end
      cyc(); #1;
      check("tie_bubble_grant", grant_export, 2'b00);
      check("tie_bubble_write", am_if.write, 1'b0);
      set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         check("tie_r1_grant", grant_export, 2'b10);
         check("tie_r1_addr", am_if.address, 32'h4000);
      end
      cyc(); #1;
      check("tie_r1_release", grant_export, 2'b00);
      set_req(REQ_AUX, 1'b0, 1'b0, 5'd0, 32'h0);
      cyc();
      set_req(REQ_BLIT, 1'b0, 1'b1, 5'd1, 32'h3100);
      set_req(REQ_AUX,  1'b0, 1'b1, 5'd1, 32'h4100);
      cyc(); #1;
      check("tie_repeat_grant", grant_export, 2'b01);
      set_req(REQ_AUX, 1'b0, 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      check("tie_repeat_release", grant_export, 2'b00);
      set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);

      // Read burst of 8: 3 stalled cycles, then irregular beats; r1 waits throughout
      cyc();
      set_req(REQ_BLIT, 1'b1, 1'b0, 5'd8, 32'h5000);
      for (int i = 0; i < 3; i++) begin
         cyc();
         am_if.waitrequest = 1'b1;
         #1;
         check("rd8_grant", grant_export, 2'b01);
         check("rd8_dn_read", am_if.read, 1'b1);
         check("rd8_r0_wait", r0_if.waitrequest, 1'b1);
         if (i == 0) set_req(REQ_AUX, 1'b0, 1'b1, 5'd1, 32'h6000);
      end
      cyc();
      am_if.waitrequest = 1'b0;
      dn_beat(1'b1, REQ_BLIT, 32'hB000_0000);
      #1;
      check("rd8_accept", r0_if.waitrequest, 1'b0);
      cyc();
      set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      check("rd8_r1_wait", r1_if.waitrequest, 1'b1);
      check("rd8_no_reissue", am_if.read, 1'b0);
      for (int i = 0; i < 7; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            cyc(); #1;
            check("rd8_hold_grant", grant_export, 2'b01);
            check("rd8_r1_wait", r1_if.waitrequest, 1'b1);
         end
         cyc();
         dn_beat(1'b1, REQ_BLIT, 32'hB000_0001 + i);
         #1;
         check("rd8_hold_grant", grant_export, 2'b01);
         check("rd8_r1_wait", r1_if.waitrequest, 1'b1);
      end
      cyc(); #1;
      check("rd8_release", grant_export, 2'b00);
      check("rd8_r1_wait_idle", r1_if.waitrequest, 1'b1);
      cyc(); #1;
      check("rd8_r1_grant", grant_export, 2'b10);
      check("rd8_r1_write", am_if.write, 1'b1);
      check("rd8_r1_go", r1_if.waitrequest, 1'b0);
      cyc(); #1;
      check("rd8_r1_release", grant_export, 2'b00);
      set_req(REQ_AUX, 1'b0, 1'b0, 5'd0, 32'h0);

      // Reset during beat 3 of an 8-beat read
      cyc();
      set_req(REQ_BLIT, 1'b1, 1'b0, 5'd8, 32'h7000);
      cyc(); #1;
      check("rst_mid_grant", grant_export, 2'b01);
      cyc();
      set_req(REQ_BLIT, 1'b0, 1'b0, 5'd0, 32'h0);
      dn_beat(1'b1, REQ_BLIT, 32'hD000_0001);
      cyc();
      dn_beat(1'b1, REQ_BLIT, 32'hD000_0002);
      cyc();
      dn_beat(1'b1, REQ_BLIT, 32'hD000_0003);
      #3;
      reset = 1'b1;
      #1;
      check("rst_mid_async_grant", grant_export, 2'b00);
      check("rst_mid_async_rdv", r0_if.readdatavalid, 1'b0);
      check("rst_mid_async_wait", r0_if.waitrequest, 1'b1);
      check("rst_mid_async_read", am_if.read, 1'b0);
      cyc();
      dn_beat(1'b0, REQ_BLIT, 32'hD000_0004);
      #1;
      check("rst_mid_beat4", r0_if.readdatavalid, 1'b0);
      cyc();
      reset = 1'b0;
      dn_beat(1'b0, REQ_BLIT, 32'hD000_0005);
      #1;
      check("rst_mid_beat5", r0_if.readdatavalid, 1'b0);
      check("rst_mid_idle", grant_export, 2'b00);
      cyc();
      set_req(REQ_AUX, 1'b1, 1'b0, 5'd1, 32'h8000);
      cyc(); #1;
      check("post_rst_grant", grant_export, 2'b10);
      check("post_rst_read", am_if.read, 1'b1);
      check("post_rst_addr", am_if.address, 32'h8000);
      cyc();
      set_req(REQ_AUX, 1'b0, 1'b0, 5'd0, 32'h0);
      dn_beat(1'b1, REQ_AUX, 32'hE000_0001);
      cyc(); #1;
      check("post_rst_release", grant_export, 2'b00);

      cyc(); #3;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gdu_master_arbiter.md
# gdu_master_arbiter

Two-requester Avalon-MM master arbiter between the graphics drawing unit's blitter master and a second SDRAM client, such as the frame-buffer clear engine or the scanout prefetcher. It shares the single SDRAM master port with round-robin fairness. A grant is held until the granted requester's whole transaction completes, including every read beat. It is instantiated inside `graphics_drawing_unit` in front of the `avalon_master_*` ports.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BURST_W, 5, burstcount width

Ports. `rN_` exists for N = 0 (blitter) and N = 1 (second client).
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rN_address  in  ADDR_W  requester address
- rN_burstcount  in  BURST_W  requester burst length
- rN_byteenable  in  DATA_W/8  requester byte enables
- rN_read  in  1  requester read command
- rN_write  in  1  requester write command
- rN_writedata  in  DATA_W  requester write data
- rN_waitrequest  out  1  stall to requester
- rN_readdata  out  DATA_W  read data to requester
- rN_readdatavalid  out  1  read beat valid to requester
- avalon_master_address / burstcount / byteenable / read / write / writedata  out  (widths as rN_)  downstream command
- avalon_master_readdata  in  DATA_W  downstream read data
- avalon_master_readdatavalid  in  1  downstream read beat valid
- avalon_master_waitrequest  in  1  downstream stall
- grant_export  out  2  one-hot current grant; 00 when idle

## Operation
- States:
  - IDLE: arbitrate among requesters with rN_read|rN_write.
  - WRITE_BURST: forward write beats.
  - READ_CMD: forward the read command.
  - READ_DRAIN: wait for read beats.
- Round-robin arbitration:
  - If both request in IDLE, grant the one not granted last.
  - If one requests, grant it.
  - `last` resets to 1, so r0 wins the first tie.
- On grant, latch the requester index and its burstcount; burstcount 0 is treated as 1.
  - Write takes precedence if rN_read and rN_write are both high; the read is ignored.
  - Go to WRITE_BURST or READ_CMD.
- While granted, downstream command outputs are a combinational pass-through of the granted requester's signals.
  - rN_waitrequest(granted) = avalon_master_waitrequest.
- The non-granted requester sees rN_waitrequest = 1 and rN_readdatavalid = 0.
- rN_readdata = avalon_master_readdata, broadcast to both requesters.
- WRITE_BURST:
  - Beat counter increments on write & !waitrequest.
  - When the counter reaches the latched burstcount, go to IDLE and set last = grant.
- READ_CMD:
  - When read & !waitrequest, go to READ_DRAIN; the downstream read is not re-forwarded.
  - Downstream avalon_master_read = 0 outside READ_CMD and WRITE_BURST.
- READ_DRAIN:
  - Route readdatavalid to the granted requester only.
  - Count beats; on the last beat go to IDLE and set last = grant.
  - A beat arriving in the same cycle as the command acceptance is counted.
- Beat counter width is BURST_W+1, so no wrap occurs at the maximum burst of 16.

## Timing
- Reset (async): state IDLE, grant_export 00, last = 1, counters 0, avalon_master_read/write 0, both rN_waitrequest 1, both rN_readdatavalid 0.
- Reset mid-burst aborts the transaction immediately. Requesters must re-issue.
- Arbitration latency:
  - A request first visible in cycle T is granted at the T+1 edge.
  - Its command appears downstream in cycle T+1.
  - rN_waitrequest is high during cycle T.
- Release:
  - The final beat completes in cycle T; state is IDLE in T+1.
  - Arbitration happens in T+1; the next command appears in T+2, a 1-cycle bubble.
- A requester dropping its command while granted mid-write-burst is a protocol violation: the grant is held until the beat count completes.
- The downstream command only changes while waitrequest is low.
- All outputs other than the pass-through paths are registered.

## Structure
- Package `gdu_pkg` holds the arbiter state enum and the requester-index constants (REQ_BLIT = 0, REQ_AUX = 1).
- Shared with `graphics_drawing_unit`.
- No sub-module is needed: one module with a registered FSM plus a combinational mux.

## Test plan
- Single read, r0 only, burstcount 1, addr 0x100: grant_export = 01 in the next cycle; one r0_readdatavalid; r1_readdatavalid stays 0.
- Simultaneous r0/r1 writes with burstcount 4, after reset: r0 is served first (4 beats); r1 is granted 1 cycle after the last r0 beat. A repeat tie grants r0 again because last = r1.
- Read burst of 8 with downstream waitrequest high for 3 cycles, then beats spaced irregularly: the grant is held until the 8th readdatavalid; r1's request waits with r1_waitrequest = 1 throughout.
- Burstcount 0 write: treated as 1 beat; returns to IDLE after one accepted beat.
- r0 asserts read and write together: only the write is forwarded; avalon_master_read stays 0.
- Reset asserted mid read burst (beat 3 of 8): outputs go to reset values asynchronously; later beats are not forwarded; the next request is granted normally.
